// File: rtl/rtc_pkg.sv
// Shared types and defaults for the RTC bus scheduler and its bus muxes.
package rtc_pkg;

  typedef enum logic [2:0] {
    GAP_ST   = 3'd0,
    IDLE     = 3'd1,
    INIT_ST  = 3'd2,
    READ_ST  = 3'd3,
    WRITE_ST = 3'd4
  } state_e;

  localparam int unsigned READ_PERIOD_DEF = 1_000_000;
  localparam int unsigned GAP_DEF         = 4;
  localparam int unsigned TIMEOUT_DEF     = 4096;

  // One-hot engine select, also used to steer the data/control muxes.
  localparam int unsigned SEL_W        = 3;
  localparam int unsigned SEL_INIT_IDX = 0;
  localparam int unsigned SEL_RD_IDX   = 1;
  localparam int unsigned SEL_WR_IDX   = 2;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_NONE = 3'b000;
  localparam sel_t SEL_INIT = 3'b001;
  localparam sel_t SEL_RD   = 3'b010;
  localparam sel_t SEL_WR   = 3'b100;

  // Select pattern owned by a given scheduler state.
  function automatic sel_t state_to_sel(input state_e s);
    case (s)
      INIT_ST:  return SEL_INIT;
      READ_ST:  return SEL_RD;
      WRITE_ST: return SEL_WR;
      default:  return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/rtc_bus_scheduler_if.sv
// Handshake bundle between the scheduler and the three bus engines.
interface rtc_bus_scheduler_if;
  logic en;
  logic req_wr;
  logic done_init;
  logic done_rd;
  logic done_wr;
  logic sel_init;
  logic sel_rd;
  logic sel_wr;
  logic wr_busy;
  logic init_done;
  logic err;

  modport master (
    output en, req_wr, done_init, done_rd, done_wr,
    input  sel_init, sel_rd, sel_wr, wr_busy, init_done, err
  );

  modport slave (
    input  en, req_wr, done_init, done_rd, done_wr,
    output sel_init, sel_rd, sel_wr, wr_busy, init_done, err
  );
endinterface

// File: rtl/rtc_tick_gen.sv
// Free-running period counter producing a one-cycle read tick.
module rtc_tick_gen
  import rtc_pkg::*;
#(
  parameter int unsigned PERIOD = READ_PERIOD_DEF
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);

  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             tick_q;

  // Count 0..PERIOD-1 and flag the terminal count one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (cnt_q == CNT_W'(PERIOD - 1));
      if (cnt_q == CNT_W'(PERIOD - 1)) cnt_q <= '0;
      else                             cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/rtc_bus_scheduler.sv
// Grants the shared RTC bus to one engine at a time with a turnaround gap
// and aborts grants that never complete.
module rtc_bus_scheduler
  import rtc_pkg::*;
#(
  parameter int unsigned READ_PERIOD = READ_PERIOD_DEF,
  parameter int unsigned GAP         = GAP_DEF,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
  input logic                clk,
  input logic                reset,
  rtc_bus_scheduler_if.slave bus
);

  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e           state_q, state_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic             init_pend_q, init_pend_d;
  logic             rd_pend_q, rd_pend_d;
  logic             wr_pend_q, wr_pend_d;
  logic             init_done_q, init_done_d;
  logic             err_q, err_d;
  sel_t             sel_q;
  logic             wr_busy_q;
  logic             tick;
  logic             done_match;

  rtc_tick_gen #(.PERIOD(READ_PERIOD)) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .tick_o (tick)
  );

  // Completion pulse belonging to the engine currently granted.
  always_comb begin
    done_match = 1'b0;
    case (state_q)
      INIT_ST:  done_match = bus.done_init;
      READ_ST:  done_match = bus.done_rd;
      WRITE_ST: done_match = bus.done_wr;
      default:  done_match = 1'b0;
    endcase
  end

  // Arbitration, gap/timeout counting and pending-flag bookkeeping.
  always_comb begin
    state_d     = state_q;
    gap_d       = gap_q;
    to_d        = to_q;
    init_pend_d = init_pend_q;
    rd_pend_d   = rd_pend_q;
    wr_pend_d   = wr_pend_q;
    init_done_d = init_done_q;
    err_d       = err_q;

    case (state_q)
      GAP_ST: begin
        if (gap_q == GAP_W'(GAP - 1)) begin
          state_d = IDLE;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      IDLE: begin
        to_d = '0;
        if (bus.en) begin
          if (init_pend_q) begin
            state_d     = INIT_ST;
            init_pend_d = 1'b0;
          end else if (init_done_q && wr_pend_q) begin
            state_d   = WRITE_ST;
            wr_pend_d = 1'b0;
          end else if (init_done_q && rd_pend_q) begin
            state_d   = READ_ST;
            rd_pend_d = 1'b0;
          end
        end
      end
      INIT_ST, READ_ST, WRITE_ST: begin
        // A done on the threshold cycle still counts as completion.
        if (done_match) begin
          state_d = GAP_ST;
          if (state_q == INIT_ST) init_done_d = 1'b1;
        end else if (to_q == TO_W'(TIMEOUT - 1)) begin
          state_d = GAP_ST;
          err_d   = 1'b1;
          if (state_q == INIT_ST) init_pend_d = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      default: state_d = GAP_ST;
    endcase

    // New requests win over the clear on grant entry; reads never queue.
    if (bus.req_wr) wr_pend_d = 1'b1;
    if (tick)       rd_pend_d = 1'b1;
  end

  // State, counters, flags and registered Moore outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= GAP_ST;
      gap_q       <= '0;
      to_q        <= '0;
      init_pend_q <= 1'b1;
      rd_pend_q   <= 1'b0;
      wr_pend_q   <= 1'b0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
      sel_q       <= SEL_NONE;
      wr_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_q       <= gap_d;
      to_q        <= to_d;
      init_pend_q <= init_pend_d;
      rd_pend_q   <= rd_pend_d;
      wr_pend_q   <= wr_pend_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      sel_q       <= state_to_sel(state_d);
      wr_busy_q   <= wr_pend_d | (state_d == WRITE_ST);
    end
  end

  assign bus.sel_init  = sel_q[SEL_INIT_IDX];
  assign bus.sel_rd    = sel_q[SEL_RD_IDX];
  assign bus.sel_wr    = sel_q[SEL_WR_IDX];
  assign bus.wr_busy   = wr_busy_q;
  assign bus.init_done = init_done_q;
  assign bus.err       = err_q;

endmodule

// File: doc/rtc_bus_scheduler.md
# rtc_bus_scheduler

Sequencer and arbiter for the shared multiplexed RTC bus (AD/CS/RD/WR plus bidirectional D). Three engines share the bus: initialization, periodic time read and PicoBlaze-driven write. The scheduler grants the bus to exactly one engine at a time and inserts a turnaround gap between grants. It also aborts engines that never report completion. It replaces the ad-hoc selection in the general control FSM, and its one-hot selects drive the data and control muxes directly.

## Interface
Parameters:
- READ_PERIOD, 1_000_000 — clock cycles between periodic read requests (10 ms at 100 MHz); ≥ 2.
- GAP, 4 — idle cycles with all selects low between two grants; ≥ 1.
- TIMEOUT, 4096 — maximum cycles a grant may last before abort; ≥ 2.

Ports:
- clk  in  1  system clock; one clock domain; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  scheduling enable (EN_G); low blocks new grants; an active grant runs to completion.
- req_wr  in  1  one-cycle pulse: PicoBlaze has staged an address/data pair.
- done_init  in  1  pulse from the init engine at end of sequence.
- done_rd  in  1  pulse from the read engine at end of a full read pass.
- done_wr  in  1  pulse from the write engine (fin_wr).
- sel_init  out  1  grant/start level for the init engine and mux.
- sel_rd  out  1  grant/start level for the read engine and mux.
- sel_wr  out  1  grant/start level for the write engine and mux.
- wr_busy  out  1  high while a write is pending or granted.
- init_done  out  1  sticky; set after the first successful init.
- err  out  1  sticky; set on any timeout; cleared only by reset.

## Operation
- States: GAP_ST, IDLE, INIT_ST, READ_ST, WRITE_ST. Outputs are Moore-decoded from the state register; sel_* are mutually exclusive by construction.
- Pending flags: init_pend, rd_pend, wr_pend.
  - reset sets init_pend = 1 and clears the others.
  - A flag clears in the cycle its grant state is entered.
- Period counter: free-runs 0..READ_PERIOD-1 from reset. At the terminal count it sets rd_pend. If rd_pend is already set, the tick is merged; reads do not queue.
- req_wr sets wr_pend. This holds in any state, including WRITE_ST, so one extra write is queued. Further pulses while wr_pend = 1 are merged.
- GAP_ST: gap counter counts GAP cycles, then moves to IDLE.
- IDLE: if en = 1, grant by priority init_pend > wr_pend > rd_pend. rd_pend and wr_pend are only eligible when init_done = 1. With nothing pending, or en = 0, stay in IDLE.
- Grant states: wait for the matching done_*. Done pulses from non-granted engines are ignored.
  - On the matching done, go to GAP_ST.
  - In INIT_ST, done_init also sets init_done.
- Timeout: a per-grant counter clears on entry to a grant state. If it reaches TIMEOUT-1 without the matching done, set err and go to GAP_ST.
  - An aborted init re-sets init_pend, so init is retried.
  - An aborted write or read is dropped.
- wr_busy = wr_pend | (state == WRITE_ST).
- Reset mid-grant: sel_* drop to 0 in the reset cycle. The state, all counters and the flags return to their reset values.

## Timing
- Reset values:
  - sel_init, sel_rd, sel_wr, wr_busy, init_done, err = 0.
  - state = GAP_ST; all counters = 0.
- First grant: the first cycle with reset low is gap cycle 1. IDLE is entered after GAP cycles, and sel_init rises one cycle later, provided en = 1.
- IDLE→grant decision latency: 1 cycle.
- A done_* sampled high gives a select low on the next clock edge.
- Turnaround between any two grants: GAP + 1 cycles with all selects low.
- req_wr → wr_busy high: next clock edge.
- A simultaneous period tick and req_wr in IDLE register both flags; the write is granted first.
- A done arriving in the same cycle as the timeout threshold counts as completion: err is not set.
- Counter widths are $clog2 of the parameter value; no wrap is visible because each counter is reset at its terminal count.

## Structure
- Shared package rtc_pkg:
  - state enum: GAP_ST, IDLE, INIT_ST, READ_ST, WRITE_ST;
  - default parameter constants;
  - one-hot select encoding, reused by the mux blocks.
- One sub-module, rtc_tick_gen: the period counter with a one-cycle tick output. The arbiter FSM, the gap counter and the timeout counter stay in the top module.

## Test plan
All scenarios use READ_PERIOD = 100, GAP = 4, TIMEOUT = 50.
- Reset release with en = 1 → sel_init high exactly 5 cycles after reset falls; done_init pulse → sel_init low next cycle, init_done = 1, then 5 idle cycles.
- After init, no requests → sel_rd asserts every ~100 cycles; done_rd 10 cycles after each grant → no err, and the grant count matches elapsed time / 100.
- req_wr coinciding with a period tick in IDLE → sel_wr granted first; sel_rd follows after done_wr plus 5 idle cycles. wr_busy is high from the pulse until done_wr.
- Two req_wr pulses, the second during WRITE_ST → two sequential sel_wr grants; a third pulse while wr_pend = 1 is merged, giving no third grant.
- Grant held with no done → after 50 cycles err = 1, select low, GAP_ST; for init, sel_init re-asserts after the gap.
- Reset asserted mid-WRITE_ST → all outputs 0 on the next edge, wr_pend cleared, init sequence restarts. en = 0 in IDLE with requests pending → no grant until en returns high.
